// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator with per-frame slew limiting and a
// valid/ready position command port. Pulse widths latch only at frame boundaries.
module servo_pwm_bank #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 100_000,
  parameter int FRAME_TICKS = 2000,
  parameter int MIN_TICKS   = 100,
  parameter int MAX_TICKS   = 200,
  parameter int N_CH        = 4,
  parameter int POS_W       = 8,
  parameter int STEP        = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [POS_W-1:0]  cmd_pos,
  input  logic [N_CH-1:0]   enable,
  output logic [N_CH-1:0]   pwm_out,
  output logic [N_CH-1:0]   busy,
  output logic              frame_start
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int SPAN = MAX_TICKS - MIN_TICKS;
  localparam logic [POS_W-1:0] SPAN_V = POS_W'(SPAN);
  localparam logic [POS_W-1:0] HALF_V = POS_W'(SPAN / 2);
  localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);

  logic [PW-1:0]    r_presc;
  logic [FW-1:0]    r_frame;
  logic             r_rdy;
  logic             w_tick;
  logic             w_upd;
  logic             w_xfer;
  logic             w_ch_ok;
  logic [POS_W-1:0] w_pos_clamp;

  assign w_tick      = (r_presc == PW'(DIV - 1));
  assign w_upd       = w_tick && (r_frame == FW'(FRAME_TICKS - 1));
  assign frame_start = w_upd;
  // Commands are refused only in the boundary cycle so targets never change while cur/shd latch.
  assign cmd_ready   = r_rdy && !w_upd;
  assign w_xfer      = cmd_valid && cmd_ready;
  assign w_ch_ok     = (32'(cmd_ch) < 32'(N_CH));
  assign w_pos_clamp = (cmd_pos > SPAN_V) ? SPAN_V : cmd_pos;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc <= '0;
      r_frame <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_tick) begin
        r_presc <= '0;
        r_frame <= w_upd ? '0 : r_frame + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [POS_W-1:0] r_tgt;
      logic [POS_W-1:0] r_cur;
      logic [POS_W-1:0] r_shd;
      logic             r_en;
      logic             r_pwm;
      logic             r_busy;
      logic [POS_W-1:0] w_up;
      logic [POS_W-1:0] w_dn;
      logic [POS_W-1:0] w_cur_next;
      logic             w_hit;

      assign w_up  = r_tgt - r_cur;
      assign w_dn  = r_cur - r_tgt;
      assign w_hit = w_xfer && w_ch_ok && (cmd_ch == CH_W'(gi));

      always_comb begin
        w_cur_next = r_cur;
        if (STEP == 0)
          w_cur_next = r_tgt;
        else if (r_tgt > r_cur)
          w_cur_next = (w_up > STEP_V) ? r_cur + STEP_V : r_tgt;
        else if (r_tgt < r_cur)
          w_cur_next = (w_dn > STEP_V) ? r_cur - STEP_V : r_tgt;
      end

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          r_tgt  <= HALF_V;
          r_cur  <= HALF_V;
          r_shd  <= HALF_V;
          r_en   <= 1'b0;
          r_pwm  <= 1'b0;
          r_busy <= 1'b0;
        end else begin
          if (w_hit)
            r_tgt <= w_pos_clamp;
          if (w_upd) begin
            r_cur <= w_cur_next;
            r_shd <= w_cur_next;
            r_en  <= enable[gi];
          end
          r_pwm  <= r_en && (32'(r_frame) < (32'(MIN_TICKS) + 32'(r_shd)));
          r_busy <= (r_cur != r_tgt);
        end
      end

      assign pwm_out[gi] = r_pwm;
      assign busy[gi]    = r_busy;
    end
  endgenerate

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: measures each channel's high time per frame
// and compares against hand-computed widths (4 clocks per tick, 250-tick frames).
module tb_servo_pwm_bank;
  localparam int DIV   = 4;
  localparam int NCH   = 3;
  localparam int POSW  = 8;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_ch;
  logic [POSW-1:0] cmd_pos;
  logic [NCH-1:0]  enable;
  logic [NCH-1:0]  pwm_out;
  logic [NCH-1:0]  busy;
  logic            frame_start;

  int checks   = 0;
  int failures = 0;
  int cnt [NCH];
  int meas[NCH];
  int nfr = 0;

  servo_pwm_bank #(
    .CLK_HZ(400_000), .TICK_HZ(100_000), .FRAME_TICKS(250), .MIN_TICKS(100),
    .MAX_TICKS(200), .N_CH(NCH), .POS_W(POSW), .STEP(2)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .enable(enable), .pwm_out(pwm_out),
    .busy(busy), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // High-cycle counter per channel; latched at each frame boundary.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
    end else if (frame_start) begin
      for (int i = 0; i < NCH; i++) begin
        meas[i] = cnt[i];
        cnt[i]  = 0;
      end
      nfr++;
    end else begin
      for (int i = 0; i < NCH; i++) cnt[i] += int'(pwm_out[i]);
    end
  end

  task automatic wait_frame(input string tag);
    int  start;
    bit  seen;
    start = nfr;
    seen  = 1'b0;
    for (int n = 0; n < 1500 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (nfr != start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL %s frame_timeout got=no frame_start exp=frame_start within 1500 cycles", tag);
      failures++;
    end
  endtask

  task automatic send_cmd(input logic [1:0] ch, input logic [POSW-1:0] pos);
    int n;
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_pos   = pos;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      $display("FAIL send_cmd_ready got=%0b exp=1", cmd_ready);
      failures++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd ch=%0d pos=%0d accepted", ch, pos);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_pos = '0; enable = 3'b111;
    repeat (3) @(negedge clk);
    checks += 4;
    if (pwm_out !== 3'b000) begin $display("FAIL rst_pwm got=%b exp=000", pwm_out); failures++; end
    if (cmd_ready !== 1'b0) begin $display("FAIL rst_ready got=%b exp=0", cmd_ready); failures++; end
    if (busy !== 3'b000) begin $display("FAIL rst_busy got=%b exp=000", busy); failures++; end
    if (frame_start !== 1'b0) begin $display("FAIL rst_fs got=%b exp=0", frame_start); failures++; end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin $display("FAIL rel_ready got=%b exp=1", cmd_ready); failures++; end
    wait_frame("t1_f1");
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (meas[c] !== 0) begin $display("FAIL t1_f1_width ch%0d got=%0d cyc exp=0", c, meas[c]); failures++; end
    end
    wait_frame("t1_f2");
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (meas[c] !== 150 * DIV) begin $display("FAIL t1_f2_width ch%0d got=%0d cyc exp=%0d", c, meas[c], 150 * DIV); failures++; end
    end
    checks++;
    if (busy !== 3'b000) begin $display("FAIL t1_busy got=%b exp=000", busy); failures++; end
    $display("test_reset done");
  endtask

  task automatic test_slew;
    send_cmd(2'd0, 8'd100);
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin $display("FAIL t2_busy_start got=%b exp=1", busy[0]); failures++; end
    wait_frame("t2_cur");
    checks++;
    if (meas[0] !== 150 * DIV) begin $display("FAIL t2_cur_width got=%0d cyc exp=%0d", meas[0], 150 * DIV); failures++; end
    for (int i = 1; i <= 25; i++) begin
      wait_frame("t2_ramp");
      checks++;
      if (meas[0] !== (150 + 2 * i) * DIV) begin
        $display("FAIL t2_ramp_width frame%0d got=%0d cyc exp=%0d", i, meas[0], (150 + 2 * i) * DIV);
        failures++;
      end
      if (i == 24) begin
        checks++;
        if (busy[0] !== 1'b1) begin $display("FAIL t2_busy_198 got=%b exp=1", busy[0]); failures++; end
      end
    end
    checks += 3;
    if (busy[0] !== 1'b0) begin $display("FAIL t2_busy_done got=%b exp=0", busy[0]); failures++; end
    if (meas[1] !== 150 * DIV) begin $display("FAIL t2_ch1_width got=%0d exp=%0d", meas[1], 150 * DIV); failures++; end
    if (meas[2] !== 150 * DIV) begin $display("FAIL t2_ch2_width got=%0d exp=%0d", meas[2], 150 * DIV); failures++; end
    $display("test_slew done");
  endtask

  task automatic test_clamp;
    send_cmd(2'd0, 8'd255);
    repeat (4) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin $display("FAIL t3_busy got=%b exp=0", busy[0]); failures++; end
    for (int f = 0; f < 2; f++) begin
      wait_frame("t3");
      checks++;
      if (meas[0] !== 200 * DIV) begin $display("FAIL t3_width frame%0d got=%0d cyc exp=%0d", f, meas[0], 200 * DIV); failures++; end
    end
    $display("test_clamp done");
  endtask

  task automatic test_back_to_back;
    int e1[7] = '{150, 0, 154, 156, 158, 160, 160};
    int e2[7] = '{150, 152, 154, 154, 154, 154, 154};
    wait_frame("t4_sync");
    // Valid raised in the boundary cycle itself: must be held off for exactly one cycle.
    cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_pos = 8'd54;
    checks += 2;
    if (cmd_ready !== 1'b0) begin $display("FAIL t4_ready_upd got=%b exp=0", cmd_ready); failures++; end
    if (frame_start !== 1'b1) begin $display("FAIL t4_fs_upd got=%b exp=1", frame_start); failures++; end
    @(negedge clk);
    checks += 2;
    if (cmd_ready !== 1'b1) begin $display("FAIL t4_ready_next got=%b exp=1", cmd_ready); failures++; end
    if (frame_start !== 1'b0) begin $display("FAIL t4_fs_next got=%b exp=0", frame_start); failures++; end
    $display("cmd ch=2 pos=54 accepted after hold");
    @(negedge clk);
    cmd_ch = 2'd1; cmd_pos = 8'd10;
    @(negedge clk);
    cmd_pos = 8'd60;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd ch=1 pos=10 then pos=60 back-to-back");
    repeat (3) @(negedge clk);
    checks++;
    if (busy[2:1] !== 2'b11) begin $display("FAIL t4_busy got=%b exp=11", busy[2:1]); failures++; end
    repeat (300) @(negedge clk);
    enable[1] = 1'b0;
    for (int f = 0; f < 7; f++) begin
      wait_frame("t5");
      checks += 3;
      if (meas[0] !== 200 * DIV) begin $display("FAIL t5_ch0 frame%0d got=%0d cyc exp=%0d", f, meas[0], 200 * DIV); failures++; end
      if (meas[1] !== e1[f] * DIV) begin $display("FAIL t5_ch1 frame%0d got=%0d cyc exp=%0d", f, meas[1], e1[f] * DIV); failures++; end
      if (meas[2] !== e2[f] * DIV) begin $display("FAIL t5_ch2 frame%0d got=%0d cyc exp=%0d", f, meas[2], e2[f] * DIV); failures++; end
      if (f == 0) begin
        repeat (5) @(negedge clk);
        enable[1] = 1'b1;
      end
    end
    checks++;
    if (busy !== 3'b000) begin $display("FAIL t5_busy_end got=%b exp=000", busy); failures++; end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    wait_frame("t6_sync");
    repeat (100) @(negedge clk);
    checks++;
    if (pwm_out !== 3'b111) begin $display("FAIL t6_pre_pwm got=%b exp=111", pwm_out); failures++; end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (pwm_out !== 3'b000) begin $display("FAIL t6_async_pwm got=%b exp=000", pwm_out); failures++; end
    if (cmd_ready !== 1'b0) begin $display("FAIL t6_async_ready got=%b exp=0", cmd_ready); failures++; end
    if (busy !== 3'b000) begin $display("FAIL t6_async_busy got=%b exp=000", busy); failures++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_cmd(2'd3, 8'd0);
    wait_frame("t6_f1");
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (meas[c] !== 0) begin $display("FAIL t6_f1_width ch%0d got=%0d cyc exp=0", c, meas[c]); failures++; end
    end
    for (int f = 2; f <= 3; f++) begin
      wait_frame("t6_fn");
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (meas[c] !== 150 * DIV) begin $display("FAIL t6_f%0d_width ch%0d got=%0d cyc exp=%0d", f, c, meas[c], 150 * DIV); failures++; end
      end
      checks++;
      if (busy !== 3'b000) begin $display("FAIL t6_f%0d_busy got=%b exp=000", f, busy); failures++; end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_slew();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
